// File: rtl/reg_bank_param_if.sv
// ---------------------------------------------------------------------------
// reg_bank_param_if
// Bundles the write port, the two read ports and the written-flags vector of
// reg_bank_param.
//   master : drives wr_en/wr_addr/wr_data and rd_en_x/rd_addr_x,
//            observes rd_data_x/rd_valid_x/written
//   slave  : the register bank side (the reverse directions)
// Parameters must match those of the reg_bank_param instance attached to it.
// ---------------------------------------------------------------------------
interface reg_bank_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_valid_a;

    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_b;

    logic [DEPTH-1:0]  written;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, written
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, written
    );
endinterface

// File: rtl/reg_bank_param.sv
// ---------------------------------------------------------------------------
// reg_bank_param
// Parameterised register bank: DEPTH = 2**ADDR_W registers of DATA_W bits,
// one write port and two independent registered read ports (A and B), plus a
// per-register "written since reset" flag vector.
//
// Ports:
//   clk    : clock, all state updates on rising edge
//   reset  : synchronous active-low reset
//   bus    : reg_bank_param_if.slave (write port, read ports A/B, written)
//
// Parameters:
//   DATA_W   : register / data width
//   ADDR_W   : address width
//   ZERO_REG : 1 -> register 0 reads as zero and ignores writes
//
// Build option:
//   REG_BANK_BYPASS_EN : when defined, a read and write to the same address in
//                        the same cycle returns the write data (write-first);
//                        otherwise the read returns the old value (read-first).
// ---------------------------------------------------------------------------
module reg_bank_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic            clk,
    input  logic            reset,
    reg_bank_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NPORT = 2;

    // Register storage and written flags
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  written_q;
    logic [DEPTH-1:0]  written_d;

    // Effective write: a write to register 0 is dropped when it is hardwired
    logic wr_ok;
    assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    always_comb begin
        mem_d     = mem_q;
        written_d = written_q;
        if (wr_ok) begin
            mem_d[bus.wr_addr]     = bus.wr_data;
            written_d[bus.wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q <= '0;
        end else begin
            mem_q     <= mem_d;
            written_q <= written_d;
        end
    end

    assign bus.written = written_q;

    // Read ports gathered into arrays so both ports share one description
    logic              rd_en      [NPORT];
    logic [ADDR_W-1:0] rd_addr    [NPORT];
    logic [DATA_W-1:0] rd_data_q  [NPORT];
    logic [DATA_W-1:0] rd_data_d  [NPORT];
    logic              rd_valid_q [NPORT];
    logic              rd_valid_d [NPORT];

    assign rd_en[0]   = bus.rd_en_a;
    assign rd_addr[0] = bus.rd_addr_a;
    assign rd_en[1]   = bus.rd_en_b;
    assign rd_addr[1] = bus.rd_addr_b;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd_port
            always_comb begin
                // Hold the previous data when idle; valid only on a request
                rd_data_d[gi]  = rd_data_q[gi];
                rd_valid_d[gi] = rd_en[gi];
                if (rd_en[gi]) begin
                    if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
                        rd_data_d[gi] = '0;
`ifdef REG_BANK_BYPASS_EN
                    end else if (wr_ok && (bus.wr_addr == rd_addr[gi])) begin
                        // Forward the data being written this cycle
                        rd_data_d[gi] = bus.wr_data;
`endif
                    end else begin
                        rd_data_d[gi] = mem_q[rd_addr[gi]];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    rd_data_q[gi]  <= '0;
                    rd_valid_q[gi] <= 1'b0;
                end else begin
                    rd_data_q[gi]  <= rd_data_d[gi];
                    rd_valid_q[gi] <= rd_valid_d[gi];
                end
            end
        end
    endgenerate

    assign bus.rd_data_a  = rd_data_q[0];
    assign bus.rd_valid_a = rd_valid_q[0];
    assign bus.rd_data_b  = rd_data_q[1];
    assign bus.rd_valid_b = rd_valid_q[1];

endmodule

// File: doc/reg_bank_param.md
REG_BANK_PARAM -- requirements
Module: reg_bank_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each register and each data port.
REQ-002 SHALL have parameter ADDR_W, default 3: address width; depth DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 0: when 1, register 0 reads as zero and ignores writes.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 wr_en  input  1  write strobe.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  DATA_W  write data.
REQ-009 rd_en_a  input  1  read request, port A.
REQ-010 rd_addr_a  input  ADDR_W  read address, port A.
REQ-011 rd_data_a  output  DATA_W  registered read data, port A.
REQ-012 rd_valid_a  output  1  rd_data_a updated this cycle from a request.
REQ-013 rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: port B, identical widths and meaning to port A.
REQ-014 written  output  DEPTH  per-register flag: register written since reset.

Function
REQ-015 SHALL hold DEPTH registers of DATA_W bits.
REQ-016 When wr_en=1 at a rising edge, register wr_addr SHALL take wr_data; no other register changes.
REQ-017 When wr_en=1, written[wr_addr] SHALL be set to 1 at that edge; it remains set until reset.
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be dropped, written[0] SHALL stay 0, and reads of address 0 SHALL return 0.
REQ-019 Read latency SHALL be one cycle: rd_en_x=1 at edge N puts the addressed value on rd_data_x after edge N, and rd_valid_x=1 for that one cycle.
REQ-020 When rd_en_x=0 at an edge, rd_data_x SHALL hold its previous value and rd_valid_x SHALL be 0 (registered hold; no latch).
REQ-021 Ports A and B SHALL operate independently; both may read the same address in the same cycle with identical results.
REQ-022 Read and write at different addresses in the same cycle SHALL not interact.
REQ-023 Read and write at the same address in the same cycle SHALL follow REQ-030/REQ-031.
REQ-024 Addresses SHALL be fully decoded; every value 0..DEPTH-1 is valid, with no wrap or aliasing.
REQ-025 rd_data_x SHALL never be high-impedance; the output is always driven.

Reset
REQ-026 While reset=0 at a rising edge, all registers SHALL clear to 0, written SHALL clear to all-zero, rd_data_a/b SHALL clear to 0, and rd_valid_a/b SHALL clear to 0.
REQ-027 Reset SHALL take priority over any simultaneous write or read; the write is discarded and no rd_valid is issued.
REQ-028 Requests presented in the first cycle with reset=1 SHALL be serviced normally.
REQ-029 Reset asserted mid-operation SHALL cancel any pending read, so rd_valid is 0 on the cycle after the reset edge.

Configuration
REQ-030 When macro REG_BANK_BYPASS_EN is defined, a same-cycle write and read at the same address SHALL return wr_data, a write-first forward (subject to REQ-018).
REQ-031 When REG_BANK_BYPASS_EN is not defined, that read SHALL return the value held before the write (read-first); the new value is visible from the next read.

Verification
REQ-032 Reset then read all addresses on A -> rd_data_a=0x0000 and rd_valid_a=1 one cycle after each request; written=0.
REQ-033 Write 0xBEEF to addr 5, next cycle read addr 5 on A and B -> both return 0xBEEF with valid; written[5]=1.
REQ-034 Write 0x1234 to addr 2 with a same-cycle read of addr 2 (old value 0xAAAA) -> 0x1234 with REG_BANK_BYPASS_EN, 0xAAAA without.
REQ-035 ZERO_REG=1: write 0xFFFF to addr 0, then read addr 0 -> 0x0000, written[0]=0.
REQ-036 Read addr 3 (0x00C3), then deassert rd_en_a for 4 cycles -> rd_data_a holds 0x00C3 and rd_valid_a=0.
REQ-037 Drive reset=0 together with a write to addr 1 and reads on A and B -> addr 1 stays 0, rd_data=0, no valid pulse.
